// File: rtl/onewire_pkg.sv
// onewire_pkg: slot/reset timing constants in ticks, tick-counter width and sequencer states.
package onewire_pkg;
  localparam int CW = 10;
  localparam logic [CW-1:0] T_RSTL = 10'd480;
  localparam logic [CW-1:0] T_PDS = 10'd550;
  localparam logic [CW-1:0] T_RSTE = 10'd960;
  localparam logic [CW-1:0] T_LOW0 = 10'd60;
  localparam logic [CW-1:0] T_LOW1 = 10'd6;
  localparam logic [CW-1:0] T_SMP = 10'd15;
  localparam logic [CW-1:0] T_SLOT = 10'd70;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
endpackage

// File: rtl/onewire_sequencer_if.sv
// onewire_sequencer_if: command/response handshake between the register front end and the sequencer.
// cmd_pwr exists only when ONEWIRE_PWR_EN is defined.
interface onewire_sequencer_if;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_rst;
  logic cmd_dtx;
  logic cmd_od;
  logic rsp_valid;
  logic rsp_data;
`ifdef ONEWIRE_PWR_EN
  logic cmd_pwr;
  modport master (output cmd_valid, cmd_rst, cmd_dtx, cmd_od, cmd_pwr, input cmd_ready, rsp_valid, rsp_data);
  modport slave (input cmd_valid, cmd_rst, cmd_dtx, cmd_od, cmd_pwr, output cmd_ready, rsp_valid, rsp_data);
`else
  modport master (output cmd_valid, cmd_rst, cmd_dtx, cmd_od, input cmd_ready, rsp_valid, rsp_data);
  modport slave (input cmd_valid, cmd_rst, cmd_dtx, cmd_od, output cmd_ready, rsp_valid, rsp_data);
`endif
endinterface

// File: rtl/onewire_prescaler.sv
// onewire_prescaler: 1-tick-per-microsecond strobe; od is captured on restart and picks the divider.
module onewire_prescaler #(
  parameter int CDR_N = 50,
  parameter int CDR_O = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic od,
  output logic tick
);
  localparam int W = $clog2((CDR_N > CDR_O ? CDR_N : CDR_O) + 1);
  localparam logic [W-1:0] RN = W'(CDR_N - 1);
  localparam logic [W-1:0] RO = W'(CDR_O - 1);
  logic [W-1:0] pc;
  logic od_q;
  assign tick = pc == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RN;
      od_q <= 1'b0;
    end else if (restart) begin
      pc <= od ? RO : RN;
      od_q <= od;
    end else begin
      pc <= tick ? (od_q ? RO : RN) : pc - 1'b1;
    end
  end
endmodule

// File: rtl/onewire_sequencer.sv
// onewire_sequencer: 1-wire bit-slot sequencer (reset/presence, write-0, write-1/read).
// Define ONEWIRE_PWR_EN to add the strong pull-up output owr_pwr driven from cmd_pwr.
module onewire_sequencer
  import onewire_pkg::*;
#(
  parameter int CDR_N = 50,
  parameter int CDR_O = 6
) (
  input  logic clk,
  input  logic rst_n,
  onewire_sequencer_if.slave bus,
  output logic owr_oe,
  input  logic owr_i
`ifdef ONEWIRE_PWR_EN
  ,
  output logic owr_pwr
`endif
);
  state_t st, nx;
  logic [CW-1:0] cnt, cnt_n, t_low, t_smp, t_end;
  logic op_rst, op_dtx, s1, s2, tick, acc, smp;
  assign acc = bus.cmd_valid && bus.cmd_ready;
  assign bus.cmd_ready = st == IDLE;
  assign bus.rsp_valid = st == DONE;
  assign owr_oe = st == LOW;
  onewire_prescaler #(.CDR_N(CDR_N), .CDR_O(CDR_O)) u_pre (
    .clk(clk),
    .rst_n(rst_n),
    .restart(acc),
    .od(bus.cmd_od),
    .tick(tick)
  );
  // Phase boundaries are hit on the tick that moves the counter onto the boundary value.
  always_comb begin
    cnt_n = cnt + 1'b1;
    t_low = op_rst ? T_RSTL : op_dtx ? T_LOW1 : T_LOW0;
    t_smp = op_rst ? T_PDS : T_SMP;
    t_end = op_rst ? T_RSTE : T_SLOT;
    smp = tick && cnt_n == t_smp && (st == LOW || st == HIGH);
    nx = st == IDLE ? (acc ? LOW : IDLE) :
         st == LOW  ? (tick && cnt_n == t_low ? HIGH : LOW) :
         st == HIGH ? (tick && cnt_n == t_end ? DONE : HIGH) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      op_rst <= 1'b0;
      op_dtx <= 1'b0;
      s1 <= 1'b1;
      s2 <= 1'b1;
      bus.rsp_data <= 1'b1;
    end else begin
      st <= nx;
      s1 <= owr_i;
      s2 <= s1;
      if (acc) begin
        cnt <= '0;
        op_rst <= bus.cmd_rst;
        op_dtx <= bus.cmd_dtx;
      end else if (tick) begin
        cnt <= cnt_n;
      end
      if (smp) bus.rsp_data <= s2;
    end
  end
`ifdef ONEWIRE_PWR_EN
  logic op_pwr;
  // Pull-up switches on entering DONE and is dropped at the next accept, before owr_oe rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_pwr <= 1'b0;
      owr_pwr <= 1'b0;
    end else if (acc) begin
      op_pwr <= bus.cmd_pwr;
      owr_pwr <= 1'b0;
    end else if (st == HIGH && nx == DONE) begin
      owr_pwr <= op_pwr;
    end
  end
`endif
endmodule

// File: tb/tb_onewire_sequencer.sv
// tb_onewire_sequencer: directed slot/reset/overdrive/abort vectors with CDR_N=4, CDR_O=1.
module tb_onewire_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic slv = 1'b0;
  logic owr_i, owr_oe;
  int checks = 0;
  int errors = 0;
`ifdef ONEWIRE_PWR_EN
  logic owr_pwr;
`endif
  onewire_sequencer_if bus();
  onewire_sequencer #(.CDR_N(4), .CDR_O(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .owr_oe(owr_oe),
    .owr_i(owr_i)
`ifdef ONEWIRE_PWR_EN
    ,
    .owr_pwr(owr_pwr)
`endif
  );
  // Pulled-up line: low when the master or the slave model drives it.
  assign owr_i = !(owr_oe || slv);
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic run(input string tag, input logic r, input logic d, input logic od, input logic pwr,
                     input int lo_from, input int lo_to, input bit hold,
                     input int exp_oe, input int exp_rv, input int exp_d);
    int oe = 0, rv = -1, busy_bad = 0, pw_ov = 0, pw_rv = 0, pw_1 = 0;
    @(negedge clk);
    chk({tag, "_ready_pre"}, int'(bus.cmd_ready), 1);
    bus.cmd_rst = r;
    bus.cmd_dtx = d;
    bus.cmd_od = od;
`ifdef ONEWIRE_PWR_EN
    bus.cmd_pwr = pwr;
`endif
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 5000; k++) begin
      @(negedge clk);
      slv = k >= lo_from && k < lo_to;
      if (owr_oe) oe++;
      if (bus.cmd_ready) busy_bad++;
`ifdef ONEWIRE_PWR_EN
      if (owr_pwr && owr_oe) pw_ov++;
      if (k == 1) pw_1 = int'(owr_pwr);
      pw_rv = int'(owr_pwr);
`endif
      if (bus.rsp_valid) begin
        rv = k;
        bus.cmd_valid = 1'b0;
        break;
      end
    end
    slv = 1'b0;
    chk({tag, "_oe_cycles"}, oe, exp_oe);
    chk({tag, "_rsp_cycle"}, rv, exp_rv);
    chk({tag, "_rsp_data"}, int'(bus.rsp_data), exp_d);
    chk({tag, "_busy_ready"}, busy_bad, 0);
`ifdef ONEWIRE_PWR_EN
    chk({tag, "_pwr_overlap"}, pw_ov, 0);
    chk({tag, "_pwr_at_accept"}, pw_1, 0);
    chk({tag, "_pwr_at_rsp"}, pw_rv, int'(pwr));
`endif
    @(negedge clk);
    chk({tag, "_rsp_pulse"}, int'(bus.rsp_valid), 0);
    chk({tag, "_ready_post"}, int'(bus.cmd_ready), 1);
    chk({tag, "_data_held"}, int'(bus.rsp_data), exp_d);
  endtask
  initial begin
    int nrsp;
    bus.cmd_valid = 1'b0;
    bus.cmd_rst = 1'b0;
    bus.cmd_dtx = 1'b0;
    bus.cmd_od = 1'b0;
`ifdef ONEWIRE_PWR_EN
    bus.cmd_pwr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(bus.cmd_ready), 1);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_data", int'(bus.rsp_data), 1);
    chk("rst_oe", int'(owr_oe), 0);
`ifdef ONEWIRE_PWR_EN
    chk("rst_pwr", int'(owr_pwr), 0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run("wr1", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 24, 281, 1);
    run("wr0", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 240, 281, 0);
    run("rst_pres", 1'b1, 1'b0, 1'b0, 1'b0, 2000, 2480, 1'b0, 1920, 3841, 0);
    run("rst_none", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1920, 3841, 1);
    run("od_read", 1'b0, 1'b1, 1'b1, 1'b0, 1, 20, 1'b0, 6, 71, 0);
    @(negedge clk);
    bus.cmd_rst = 1'b1;
    bus.cmd_od = 1'b0;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_oe_before", int'(owr_oe), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_oe_after", int'(owr_oe), 0);
    chk("abort_ready", int'(bus.cmd_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nrsp = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) nrsp++;
    end
    chk("abort_no_rsp", nrsp, 0);
    run("post_abort", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 24, 281, 1);
`ifdef ONEWIRE_PWR_EN
    run("pwr_on", 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 24, 281, 1);
    chk("pwr_held_idle", int'(owr_pwr), 1);
    run("pwr_off", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 24, 281, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
